// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer (IF/ID/EX/MEM/WB).
// Drives the enables of the datapath registers, the regfile strobes and the memory strobes.
// The FSM advances on posedge clk. The datapath registers capture on negedge clk.
// Strobes are combinational from state, opcode/funct, zero and mem_ready.
// Optional feature macro: MC_PERF_CNT_EN adds the retired_cnt output and its counter.
module mc_ctrl_fsm #(
  parameter int CNT_W      = 32,
  parameter int MEM_TO_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ir_en,
  output logic       ab_en,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic       alu_bsel,
  output logic       mdr_en,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic       rf_dsel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [2:0] state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDU = 4'd0,
    OP_SUBU = 4'd1,
    OP_ORI  = 4'd2,
    OP_LUI  = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_J    = 4'd7,
    OP_ILL  = 4'd8
  } op_t;

  // Wait counter only needs to reach MEM_TO_MAX; a zero limit disables the timeout.
  localparam int             WCW    = (MEM_TO_MAX > 1) ? $clog2(MEM_TO_MAX + 1) : 1;
  localparam logic [WCW-1:0] TO_MAX = WCW'(MEM_TO_MAX);
  localparam logic           TO_ON  = (MEM_TO_MAX != 0);

  state_t         state, next_state;
  op_t            op;
  logic [WCW-1:0] wait_cnt;
  logic           mem_wait;

  logic       pc_en_s, ir_en_s, ab_en_s, alu_en_s, alu_bsel_s, mdr_en_s;
  logic       rf_we_s, rf_wsel_s, rf_dsel_s, mem_rd_s, mem_wr_s, instr_done_s, illegal_s;
  logic [1:0] pc_src_s, alu_op_s;

  // Instruction class decode from the IR opcode/funct fields.
  always_comb begin
    op = OP_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: op = OP_ADDU;
          6'b100011: op = OP_SUBU;
          default:   op = OP_ILL;
        endcase
      end
      6'b001101: op = OP_ORI;
      6'b001111: op = OP_LUI;
      6'b100011: op = OP_LW;
      6'b101011: op = OP_SW;
      6'b000100: op = OP_BEQ;
      6'b000010: op = OP_J;
      default:   op = OP_ILL;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and raw strobe generation for each state.
  always_comb begin
    next_state   = state;
    pc_en_s      = 1'b0;
    pc_src_s     = 2'd0;
    ir_en_s      = 1'b0;
    ab_en_s      = 1'b0;
    alu_en_s     = 1'b0;
    alu_op_s     = 2'd0;
    alu_bsel_s   = 1'b0;
    mdr_en_s     = 1'b0;
    rf_we_s      = 1'b0;
    rf_wsel_s    = 1'b0;
    rf_dsel_s    = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    case (state)
      S_IF: begin
        mem_rd_s = 1'b1;
        if (mem_ready) begin
          ir_en_s    = 1'b1;
          pc_en_s    = 1'b1;
          next_state = S_ID;
        end else begin
          next_state = S_IF;
        end
      end
      S_ID: begin
        ab_en_s = 1'b1;
        if (op == OP_ILL) begin
          illegal_s  = 1'b1;
          next_state = S_IF;
        end else begin
          next_state = S_EX;
        end
      end
      S_EX: begin
        alu_en_s = 1'b1;
        case (op)
          OP_ADDU: begin alu_op_s = 2'd0; next_state = S_WB; end
          OP_SUBU: begin alu_op_s = 2'd1; next_state = S_WB; end
          OP_ORI:  begin alu_op_s = 2'd2; alu_bsel_s = 1'b1; next_state = S_WB; end
          OP_LUI:  begin alu_op_s = 2'd3; alu_bsel_s = 1'b1; next_state = S_WB; end
          OP_LW, OP_SW: begin
            alu_op_s   = 2'd0;
            alu_bsel_s = 1'b1;
            next_state = S_MEM;
          end
          OP_BEQ: begin
            alu_op_s     = 2'd1;
            pc_en_s      = zero;
            pc_src_s     = 2'd1;
            instr_done_s = 1'b1;
            next_state   = S_IF;
          end
          OP_J: begin
            pc_en_s      = 1'b1;
            pc_src_s     = 2'd2;
            instr_done_s = 1'b1;
            next_state   = S_IF;
          end
          default: next_state = S_IF;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          mem_wr_s = 1'b1;
          if (mem_ready) begin
            instr_done_s = 1'b1;
            next_state   = S_IF;
          end else begin
            next_state = S_MEM;
          end
        end else begin
          mem_rd_s = 1'b1;
          if (mem_ready) begin
            mdr_en_s   = 1'b1;
            next_state = S_WB;
          end else begin
            next_state = S_MEM;
          end
        end
      end
      S_WB: begin
        rf_we_s      = 1'b1;
        rf_wsel_s    = (op == OP_ORI) || (op == OP_LUI) || (op == OP_LW);
        rf_dsel_s    = (op == OP_LW);
        instr_done_s = 1'b1;
        next_state   = S_IF;
      end
      default: next_state = S_IF;
    endcase
  end

  // Output stage: reset silences every strobe so nothing partial reaches the datapath.
  always_comb begin
    if (rst) begin
      pc_en      = 1'b0;
      pc_src     = 2'd0;
      ir_en      = 1'b0;
      ab_en      = 1'b0;
      alu_en     = 1'b0;
      alu_op     = 2'd0;
      alu_bsel   = 1'b0;
      mdr_en     = 1'b0;
      rf_we      = 1'b0;
      rf_wsel    = 1'b0;
      rf_dsel    = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end else begin
      pc_en      = pc_en_s;
      pc_src     = pc_src_s;
      ir_en      = ir_en_s;
      ab_en      = ab_en_s;
      alu_en     = alu_en_s;
      alu_op     = alu_op_s;
      alu_bsel   = alu_bsel_s;
      mdr_en     = mdr_en_s;
      rf_we      = rf_we_s;
      rf_wsel    = rf_wsel_s;
      rf_dsel    = rf_dsel_s;
      mem_rd     = mem_rd_s;
      mem_wr     = mem_wr_s;
      instr_done = instr_done_s;
      illegal    = illegal_s;
    end
  end

  assign state_o  = state;
  assign mem_wait = ((state == S_IF) || (state == S_MEM)) && !mem_ready;

  // Memory wait counter (saturating) and sticky timeout flag; waiting itself never stops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (mem_wait && TO_ON) begin
      if (wait_cnt != TO_MAX) begin
        wait_cnt <= wait_cnt + WCW'(1);
      end else begin
        wait_cnt <= wait_cnt;
      end
      if (wait_cnt == (TO_MAX - WCW'(1))) begin
        mem_timeout <= 1'b1;
      end else begin
        mem_timeout <= mem_timeout;
      end
    end else begin
      wait_cnt    <= '0;
      mem_timeout <= mem_timeout;
    end
  end

`ifdef MC_PERF_CNT_EN
  // Retired-instruction counter; illegal instructions never raise instr_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if (instr_done) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end else begin
      retired_cnt <= retired_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus pushes the hand-written expected output
// vector for each cycle; the monitor pops and compares on the falling edge.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_NONE = 6'b000000;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_en, ir_en, ab_en, alu_en, alu_bsel, mdr_en, rf_we, rf_wsel, rf_dsel;
  logic       mem_rd, mem_wr, instr_done, illegal, mem_timeout;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [7:0] retired_cnt;
`endif

  int total = 0;
  int bad   = 0;

  string       qn[$];
  logic [20:0] qv[$];

  mc_ctrl_fsm #(.CNT_W(8), .MEM_TO_MAX(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .ir_en(ir_en),
    .ab_en(ab_en), .alu_en(alu_en), .alu_op(alu_op), .alu_bsel(alu_bsel),
    .mdr_en(mdr_en), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_dsel(rf_dsel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .instr_done(instr_done), .illegal(illegal),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout matches the monitor's packing of the DUT outputs.
  function automatic logic [20:0] e(input logic [2:0] st, input logic pce, input logic [1:0] pcs,
                                    input logic ire, input logic abe, input logic alue,
                                    input logic [1:0] aop, input logic bs, input logic mdre,
                                    input logic rfwe, input logic ws, input logic ds,
                                    input logic rd, input logic wr, input logic dn,
                                    input logic il, input logic to);
    return {st, pce, pcs, ire, abe, alue, aop, bs, mdre, rfwe, ws, ds, rd, wr, dn, il, to};
  endfunction

  function automatic logic [20:0] fif(input logic rdy, input logic to);
    return e(3'd0, rdy, 2'd0, rdy, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b0, 1'b0, 1'b0, to);
  endfunction

  function automatic logic [20:0] fid(input logic il);
    return e(3'd1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, il, 1'b0);
  endfunction

  function automatic logic [20:0] fex(input logic [1:0] aop, input logic bs, input logic pce,
                                      input logic [1:0] pcs, input logic dn);
    return e(3'd2, pce, pcs, 1'b0, 1'b0, 1'b1, aop, bs, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, dn, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] fmem(input logic rd, input logic wr, input logic mdre,
                                       input logic dn);
    return e(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, mdre, 1'b0, 1'b0, 1'b0,
             rd, wr, dn, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] fwb(input logic ws, input logic ds);
    return e(3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, ws, ds,
             1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // Drive one cycle of inputs, queue its expectation, advance past the next rising edge.
  task automatic cyc(input string n, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [20:0] v);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
    qn.push_back(n);
    qv.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented outputs against the oldest queued expectation.
  always @(negedge clk) begin
    logic [20:0] got;
    logic [20:0] want;
    string       nm;
    if (qv.size() > 0) begin
      nm   = qn.pop_front();
      want = qv.pop_front();
      got  = {state_o, pc_en, pc_src, ir_en, ab_en, alu_en, alu_op, alu_bsel, mdr_en,
              rf_we, rf_wsel, rf_dsel, mem_rd, mem_wr, instr_done, illegal, mem_timeout};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got=%h expected=%h", nm, got, want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    opcode    = OP_R;
    funct     = F_ADDU;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset with mem_ready high: everything quiet, state IF.
    cyc("rst_a", OP_R, F_ADDU, 1'b0, 1'b1, 21'd0);
    cyc("rst_b", OP_R, F_ADDU, 1'b0, 1'b1, 21'd0);
    rst = 1'b0;
    cyc("if_wait", OP_R, F_ADDU, 1'b0, 1'b0, fif(1'b0, 1'b0));

    // addu
    cyc("addu_if", OP_R, F_ADDU, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("addu_id", OP_R, F_ADDU, 1'b0, 1'b1, fid(1'b0));
    cyc("addu_ex", OP_R, F_ADDU, 1'b0, 1'b1, fex(2'd0, 1'b0, 1'b0, 2'd0, 1'b0));
    cyc("addu_wb", OP_R, F_ADDU, 1'b0, 1'b1, fwb(1'b0, 1'b0));
    // subu
    cyc("subu_if", OP_R, F_SUBU, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("subu_id", OP_R, F_SUBU, 1'b0, 1'b1, fid(1'b0));
    cyc("subu_ex", OP_R, F_SUBU, 1'b0, 1'b1, fex(2'd1, 1'b0, 1'b0, 2'd0, 1'b0));
    cyc("subu_wb", OP_R, F_SUBU, 1'b0, 1'b1, fwb(1'b0, 1'b0));
    // ori with mem_ready low outside IF/MEM (must be ignored)
    cyc("ori_if", OP_ORI, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("ori_id", OP_ORI, F_NONE, 1'b0, 1'b0, fid(1'b0));
    cyc("ori_ex", OP_ORI, F_NONE, 1'b0, 1'b0, fex(2'd2, 1'b1, 1'b0, 2'd0, 1'b0));
    cyc("ori_wb", OP_ORI, F_NONE, 1'b0, 1'b0, fwb(1'b1, 1'b0));
    // lui
    cyc("lui_if", OP_LUI, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("lui_id", OP_LUI, F_NONE, 1'b0, 1'b1, fid(1'b0));
    cyc("lui_ex", OP_LUI, F_NONE, 1'b0, 1'b1, fex(2'd3, 1'b1, 1'b0, 2'd0, 1'b0));
    cyc("lui_wb", OP_LUI, F_NONE, 1'b0, 1'b1, fwb(1'b1, 1'b0));
    // lw with three wait cycles in MEM
    cyc("lw_if", OP_LW, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("lw_id", OP_LW, F_NONE, 1'b0, 1'b1, fid(1'b0));
    cyc("lw_ex", OP_LW, F_NONE, 1'b0, 1'b1, fex(2'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      cyc("lw_mem_wait", OP_LW, F_NONE, 1'b0, 1'b0, fmem(1'b1, 1'b0, 1'b0, 1'b0));
    end
    cyc("lw_mem_rdy", OP_LW, F_NONE, 1'b0, 1'b1, fmem(1'b1, 1'b0, 1'b1, 1'b0));
    cyc("lw_wb", OP_LW, F_NONE, 1'b0, 1'b1, fwb(1'b1, 1'b1));
    // sw
    cyc("sw_if", OP_SW, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("sw_id", OP_SW, F_NONE, 1'b0, 1'b1, fid(1'b0));
    cyc("sw_ex", OP_SW, F_NONE, 1'b0, 1'b1, fex(2'd0, 1'b1, 1'b0, 2'd0, 1'b0));
    cyc("sw_mem", OP_SW, F_NONE, 1'b0, 1'b1, fmem(1'b0, 1'b1, 1'b0, 1'b1));
    // beq taken and not taken
    cyc("beq1_if", OP_BEQ, F_NONE, 1'b1, 1'b1, fif(1'b1, 1'b0));
    cyc("beq1_id", OP_BEQ, F_NONE, 1'b1, 1'b1, fid(1'b0));
    cyc("beq1_ex", OP_BEQ, F_NONE, 1'b1, 1'b1, fex(2'd1, 1'b0, 1'b1, 2'd1, 1'b1));
    cyc("beq0_if", OP_BEQ, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("beq0_id", OP_BEQ, F_NONE, 1'b0, 1'b1, fid(1'b0));
    cyc("beq0_ex", OP_BEQ, F_NONE, 1'b0, 1'b1, fex(2'd1, 1'b0, 1'b0, 2'd1, 1'b1));
    // j
    cyc("j_if", OP_J, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("j_id", OP_J, F_NONE, 1'b0, 1'b1, fid(1'b0));
    cyc("j_ex", OP_J, F_NONE, 1'b0, 1'b1, fex(2'd0, 1'b0, 1'b1, 2'd2, 1'b1));
    // illegal opcode, then illegal R funct
    cyc("bad_if", OP_BAD, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("bad_id", OP_BAD, F_NONE, 1'b0, 1'b1, fid(1'b1));
    cyc("badf_if", OP_R, F_ADD, 1'b0, 1'b1, fif(1'b1, 1'b0));
    cyc("badf_id", OP_R, F_ADD, 1'b0, 1'b1, fid(1'b1));
`ifdef MC_PERF_CNT_EN
    total++;
    if (retired_cnt !== 8'd9) begin
      bad++;
      $display("FAIL retired_9: got=%0d expected=9", retired_cnt);
    end
`endif
    // Timeout: limit 4, flag visible from the fifth wait cycle, mem_rd held.
    for (int i = 0; i < 4; i++) begin
      cyc("to_wait_pre", OP_J, F_NONE, 1'b0, 1'b0, fif(1'b0, 1'b0));
    end
    cyc("to_wait_set", OP_J, F_NONE, 1'b0, 1'b0, fif(1'b0, 1'b1));
    cyc("to_wait_sticky", OP_J, F_NONE, 1'b0, 1'b0, fif(1'b0, 1'b1));
    cyc("to_if_rdy", OP_J, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b1));
    // Reset while in ID aborts and clears the sticky flag.
    rst = 1'b1;
    cyc("abort_rst", OP_J, F_NONE, 1'b0, 1'b1, 21'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc("j3_if", OP_J, F_NONE, 1'b0, 1'b1, fif(1'b1, 1'b0));
      cyc("j3_id", OP_J, F_NONE, 1'b0, 1'b1, fid(1'b0));
      cyc("j3_ex", OP_J, F_NONE, 1'b0, 1'b1, fex(2'd0, 1'b0, 1'b1, 2'd2, 1'b1));
    end
`ifdef MC_PERF_CNT_EN
    total++;
    if (retired_cnt !== 8'd3) begin
      bad++;
      $display("FAIL retired_3: got=%0d expected=3", retired_cnt);
    end
`endif
    @(negedge clk);
    #1;
    total++;
    if (qv.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", qv.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
